// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared CPU fetch definitions: fetch FSM encoding, reset vector and the
// fetch exception bit layout handed to the IF/ID register.
package pc_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FLUSH = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    localparam int FETCH_EXC_W    = 8;
    localparam int FETCH_EXC_ADEL = 0;

    // Sequential successor of a PC; wraps modulo 2^32.
    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// SRAM-like instruction fetch bus: one request/accept handshake followed by
// a separate data return, at most one request outstanding.
interface pc_fetch_ctrl_if;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );

endinterface

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, issues one fetch at a time,
// holds returned words across pipeline stalls and flushes on interrupts.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall0,
    input  logic                   stall1,
    input  logic                   stall2,
    input  logic                   stall3,
    input  logic                   irq,
    input  logic [31:0]            exc_vector,
    input  logic                   branch_taken,
    input  logic [31:0]            branch_target,
    input  logic                   id_is_branch,
    pc_fetch_ctrl_if.master        fetch_bus,
    output logic [31:0]            PC_plus4,
    output logic [31:0]            Instruction,
    output logic                   is_delayslot,
    output logic [FETCH_EXC_W-1:0] fetch_exc,
    output logic                   fetch_stall
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  buf_q, buf_d;

    logic         pipe_stall;
    logic         pc_bad;
    logic         valid;
    logic         advance;
    logic [31:0]  pc_next;

    assign pipe_stall = (stall0 | stall1 | stall2 | stall3) & ~irq;
    assign pc_bad     = pc_misaligned(pc_q);
    assign pc_next    = branch_taken ? branch_target : seq_pc(pc_q);

    // Outputs are gated by rst_n so nothing stale escapes while reset is held.
    always_comb begin
        valid = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                S_REQ:   valid = pc_bad;
                S_WAIT:  valid = fetch_bus.inst_data_ok;
                S_HOLD:  valid = 1'b1;
                S_FLUSH: valid = 1'b0;
                default: valid = 1'b0;
            endcase
        end
    end

    assign advance     = valid & ~pipe_stall & ~irq;
    assign fetch_stall = rst_n ? (~valid & ~irq) : 1'b1;

    assign fetch_bus.inst_req  = rst_n && (state_q == S_REQ) && !pc_bad;
    assign fetch_bus.inst_addr = pc_q;

    assign PC_plus4     = seq_pc(pc_q);
    assign is_delayslot = id_is_branch;

    always_comb begin
        Instruction = '0;
        if (valid) begin
            unique case (state_q)
                S_WAIT:  Instruction = fetch_bus.inst_rdata;
                S_HOLD:  Instruction = buf_q;
                default: Instruction = '0;
            endcase
        end
    end

    always_comb begin
        fetch_exc                 = '0;
        fetch_exc[FETCH_EXC_ADEL] = rst_n && (state_q == S_REQ) && pc_bad;
    end

    // NOTE: every always_comb target gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;

        if (irq) begin
            pc_d = exc_vector;
            unique case (state_q)
                // An accepted request still owes us a data beat; drain it in S_FLUSH.
                S_REQ:   state_d = (!pc_bad && fetch_bus.inst_addr_ok) ? S_FLUSH : S_REQ;
                S_WAIT:  state_d = fetch_bus.inst_data_ok ? S_REQ : S_FLUSH;
                S_HOLD:  state_d = S_REQ;
                S_FLUSH: state_d = fetch_bus.inst_data_ok ? S_REQ : S_FLUSH;
                default: state_d = S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (pc_bad) begin
                        if (advance) pc_d = pc_next;
                    end else if (fetch_bus.inst_addr_ok) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (fetch_bus.inst_data_ok) begin
                        if (advance) begin
                            pc_d    = pc_next;
                            state_d = S_REQ;
                        end else begin
                            buf_d   = fetch_bus.inst_rdata;
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (advance) begin
                        pc_d    = pc_next;
                        state_d = S_REQ;
                    end
                end
                S_FLUSH: begin
                    if (fetch_bus.inst_data_ok) state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            // NOTE: the hold buffer is a plain register, so it is reset; larger
            // storage arrays would normally be left unreset.
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall0, stall1, stall2, stall3;
    logic        irq;
    logic [31:0] exc_vector;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        id_is_branch;
    logic [31:0] PC_plus4;
    logic [31:0] Instruction;
    logic        is_delayslot;
    logic [7:0]  fetch_exc;
    logic        fetch_stall;

    int tests_run    = 0;
    int tests_failed = 0;

    pc_fetch_ctrl_if bus ();

    pc_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall0        (stall0),
        .stall1        (stall1),
        .stall2        (stall2),
        .stall3        (stall3),
        .irq           (irq),
        .exc_vector    (exc_vector),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .id_is_branch  (id_is_branch),
        .fetch_bus     (bus),
        .PC_plus4      (PC_plus4),
        .Instruction   (Instruction),
        .is_delayslot  (is_delayslot),
        .fetch_exc     (fetch_exc),
        .fetch_stall   (fetch_stall)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        stall0 = 0; stall1 = 0; stall2 = 0; stall3 = 0;
        irq = 0; exc_vector = '0;
        branch_taken = 0; branch_target = '0; id_is_branch = 0;
        bus.inst_addr_ok = 0; bus.inst_data_ok = 0; bus.inst_rdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // Leaves the bench 1 time unit after the last reset edge with rst_n high.
    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        irq = 1; branch_taken = 1; branch_target = 32'h0000_1234;
        bus.inst_addr_ok = 1; bus.inst_data_ok = 1; bus.inst_rdata = 32'hA5A5_A5A5;
        repeat (2) @(posedge clk);
        #1;
        tests_run++; if (bus.inst_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %0b want 0", bus.inst_req); end
        tests_run++; if (fetch_stall !== 1'b1) begin tests_failed++; $display("FAIL reset_fetch_stall: got %0b want 1", fetch_stall); end
        tests_run++; if (Instruction !== 32'h0) begin tests_failed++; $display("FAIL reset_instr: got %h want 0", Instruction); end
        tests_run++; if (fetch_exc !== 8'h00) begin tests_failed++; $display("FAIL reset_exc: got %h want 00", fetch_exc); end
        tests_run++; if (bus.inst_addr !== RST_PC) begin tests_failed++; $display("FAIL reset_pc: got %h want %h", bus.inst_addr, RST_PC); end
        idle_inputs();
        rst_n = 1'b1;
        #1;
        tests_run++; if (bus.inst_req !== 1'b1) begin tests_failed++; $display("FAIL reset_release_req: got %0b want 1", bus.inst_req); end
    endtask

    task automatic test_basic_fetch();
        apply_reset();
        #1;  // cycle 0: request held, not accepted
        tests_run++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== RST_PC) begin tests_failed++; $display("FAIL basic_req0: req=%0b addr=%h want 1 %h", bus.inst_req, bus.inst_addr, RST_PC); end
        next_cycle(); bus.inst_addr_ok = 1; #1;  // cycle 1: accept
        tests_run++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== RST_PC) begin tests_failed++; $display("FAIL basic_req1: req=%0b addr=%h want 1 %h", bus.inst_req, bus.inst_addr, RST_PC); end
        next_cycle(); #1;  // cycle 2: waiting
        tests_run++; if (bus.inst_req !== 1'b0 || fetch_stall !== 1'b1) begin tests_failed++; $display("FAIL basic_wait: req=%0b stall=%0b want 0 1", bus.inst_req, fetch_stall); end
        next_cycle(); bus.inst_data_ok = 1; bus.inst_rdata = 32'h2402_0001; #1;  // cycle 3
        tests_run++; if (Instruction !== 32'h2402_0001 || fetch_stall !== 1'b0) begin tests_failed++; $display("FAIL basic_data: instr=%h stall=%0b want 24020001 0", Instruction, fetch_stall); end
        tests_run++; if (PC_plus4 !== 32'hBFC0_0004) begin tests_failed++; $display("FAIL basic_pc4: got %h want bfc00004", PC_plus4); end
        next_cycle(); #1;
        tests_run++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC0_0004) begin tests_failed++; $display("FAIL basic_next: req=%0b addr=%h want 1 bfc00004", bus.inst_req, bus.inst_addr); end
    endtask

    task automatic test_stall_hold();
        apply_reset();
        bus.inst_addr_ok = 1; #1;
        next_cycle(); bus.inst_data_ok = 1; bus.inst_rdata = 32'h8C43_0010; stall2 = 1; #1;
        tests_run++; if (Instruction !== 32'h8C43_0010) begin tests_failed++; $display("FAIL hold_first: got %h want 8c430010", Instruction); end
        for (int i = 0; i < 2; i++) begin
            next_cycle(); stall2 = 1; bus.inst_rdata = 32'hFFFF_0000; #1;
            tests_run++; if (Instruction !== 32'h8C43_0010 || bus.inst_req !== 1'b0 || bus.inst_addr !== RST_PC) begin tests_failed++; $display("FAIL hold_cycle%0d: instr=%h req=%0b addr=%h", i, Instruction, bus.inst_req, bus.inst_addr); end
        end
        next_cycle(); #1;
        tests_run++; if (Instruction !== 32'h8C43_0010 || fetch_stall !== 1'b0) begin tests_failed++; $display("FAIL hold_release: instr=%h stall=%0b want 8c430010 0", Instruction, fetch_stall); end
        next_cycle(); #1;
        tests_run++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC0_0004) begin tests_failed++; $display("FAIL hold_next: req=%0b addr=%h want 1 bfc00004", bus.inst_req, bus.inst_addr); end
    endtask

    task automatic test_branch();
        apply_reset();
        bus.inst_addr_ok = 1; #1;
        next_cycle(); #1;
        tests_run++; if (is_delayslot !== 1'b0) begin tests_failed++; $display("FAIL branch_no_ds: got %0b want 0", is_delayslot); end
        next_cycle();
        bus.inst_data_ok = 1; bus.inst_rdata = 32'h0000_0000;
        id_is_branch = 1; branch_taken = 1; branch_target = 32'hBFC0_0100; #1;
        tests_run++; if (is_delayslot !== 1'b1 || fetch_stall !== 1'b0) begin tests_failed++; $display("FAIL branch_ds: ds=%0b stall=%0b want 1 0", is_delayslot, fetch_stall); end
        next_cycle(); #1;
        tests_run++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC0_0100) begin tests_failed++; $display("FAIL branch_target: req=%0b addr=%h want 1 bfc00100", bus.inst_req, bus.inst_addr); end
    endtask

    task automatic test_irq_flush();
        apply_reset();
        bus.inst_addr_ok = 1; #1;
        next_cycle(); irq = 1; exc_vector = 32'hBFC0_0380; #1;
        tests_run++; if (fetch_stall !== 1'b0 || bus.inst_req !== 1'b0) begin tests_failed++; $display("FAIL irq_cycle: stall=%0b req=%0b want 0 0", fetch_stall, bus.inst_req); end
        next_cycle(); #1;
        tests_run++; if (bus.inst_req !== 1'b0 || fetch_stall !== 1'b1 || bus.inst_addr !== 32'hBFC0_0380) begin tests_failed++; $display("FAIL irq_flush: req=%0b stall=%0b addr=%h want 0 1 bfc00380", bus.inst_req, fetch_stall, bus.inst_addr); end
        next_cycle(); bus.inst_data_ok = 1; bus.inst_rdata = 32'hDEAD_BEEF; #1;
        tests_run++; if (Instruction !== 32'h0 || fetch_stall !== 1'b1) begin tests_failed++; $display("FAIL irq_discard: instr=%h stall=%0b want 0 1", Instruction, fetch_stall); end
        next_cycle(); #1;
        tests_run++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC0_0380) begin tests_failed++; $display("FAIL irq_refetch: req=%0b addr=%h want 1 bfc00380", bus.inst_req, bus.inst_addr); end
    endtask

    task automatic test_misaligned();
        apply_reset();
        bus.inst_addr_ok = 1; #1;
        next_cycle(); bus.inst_data_ok = 1; branch_taken = 1; branch_target = 32'hBFC0_0102; #1;
        next_cycle(); stall0 = 1; #1;
        tests_run++; if (bus.inst_req !== 1'b0 || fetch_exc !== 8'h01 || Instruction !== 32'h0 || fetch_stall !== 1'b0) begin tests_failed++; $display("FAIL mis_deliver: req=%0b exc=%h instr=%h stall=%0b want 0 01 0 0", bus.inst_req, fetch_exc, Instruction, fetch_stall); end
        tests_run++; if (PC_plus4 !== 32'hBFC0_0106) begin tests_failed++; $display("FAIL mis_pc4: got %h want bfc00106", PC_plus4); end
        next_cycle(); #1;  // stalled last cycle: pc unchanged, now advances
        tests_run++; if (bus.inst_addr !== 32'hBFC0_0102 || fetch_exc !== 8'h01) begin tests_failed++; $display("FAIL mis_stalled: addr=%h exc=%h want bfc00102 01", bus.inst_addr, fetch_exc); end
        next_cycle(); branch_taken = 1; branch_target = 32'hBFC0_0200; #1;
        tests_run++; if (bus.inst_addr !== 32'hBFC0_0106 || fetch_exc !== 8'h01) begin tests_failed++; $display("FAIL mis_seq: addr=%h exc=%h want bfc00106 01", bus.inst_addr, fetch_exc); end
        next_cycle(); #1;
        tests_run++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC0_0200 || fetch_exc !== 8'h00) begin tests_failed++; $display("FAIL mis_recover: req=%0b addr=%h exc=%h want 1 bfc00200 00", bus.inst_req, bus.inst_addr, fetch_exc); end
    endtask

    task automatic test_wrap();
        apply_reset();
        bus.inst_addr_ok = 1; #1;
        next_cycle(); bus.inst_data_ok = 1; branch_taken = 1; branch_target = 32'hFFFF_FFFC; #1;
        next_cycle(); bus.inst_addr_ok = 1; #1;
        tests_run++; if (bus.inst_addr !== 32'hFFFF_FFFC || PC_plus4 !== 32'h0) begin tests_failed++; $display("FAIL wrap_pc4: addr=%h pc4=%h want fffffffc 0", bus.inst_addr, PC_plus4); end
        next_cycle(); bus.inst_data_ok = 1; #1;
        next_cycle(); #1;
        tests_run++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h0) begin tests_failed++; $display("FAIL wrap_next: req=%0b addr=%h want 1 0", bus.inst_req, bus.inst_addr); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.inst_addr_ok = 1; #1;
        next_cycle(); bus.inst_data_ok = 1; #1;
        next_cycle(); bus.inst_addr_ok = 1; #1;  // second fetch at RST_PC+4
        next_cycle(); rst_n = 1'b0; #1;          // in S_WAIT
        tests_run++; if (bus.inst_req !== 1'b0 || fetch_stall !== 1'b1) begin tests_failed++; $display("FAIL rstmid_now: req=%0b stall=%0b want 0 1", bus.inst_req, fetch_stall); end
        next_cycle(); bus.inst_data_ok = 1; #1;
        tests_run++; if (bus.inst_req !== 1'b0 || bus.inst_addr !== RST_PC || Instruction !== 32'h0) begin tests_failed++; $display("FAIL rstmid_held: req=%0b addr=%h instr=%h want 0 %h 0", bus.inst_req, bus.inst_addr, Instruction, RST_PC); end
        next_cycle(); rst_n = 1'b1; #1;
        tests_run++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== RST_PC) begin tests_failed++; $display("FAIL rstmid_release: req=%0b addr=%h want 1 %h", bus.inst_req, bus.inst_addr, RST_PC); end
    endtask

    // Reference model: tracks the PC, whether a request is in flight, whether
    // that in-flight beat must be thrown away, and whether a word is parked.
    task automatic test_random();
        logic [31:0] m_pc, m_word;
        bit          m_inflight, m_drop, m_parked;
        bit          s_out;
        int          s_cnt;
        bit          idle, mis, fresh, any_stall, e_valid, e_req, e_fs, take, accepted;
        logic [31:0] e_ins;
        logic [7:0]  e_exc;

        apply_reset();
        m_pc = RST_PC; m_word = '0; m_inflight = 0; m_drop = 0; m_parked = 0;
        s_out = 0; s_cnt = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            stall0 = ($urandom_range(0, 5) == 0);
            stall1 = ($urandom_range(0, 9) == 0);
            stall2 = ($urandom_range(0, 5) == 0);
            stall3 = ($urandom_range(0, 9) == 0);
            irq = ($urandom_range(0, 15) == 0);
            exc_vector = $urandom & 32'hFFFF_FFFC;
            branch_taken = ($urandom_range(0, 2) == 0);
            branch_target = $urandom;
            if ($urandom_range(0, 5) != 0) branch_target[1:0] = 2'b00;
            id_is_branch = ($urandom_range(0, 1) == 1);
            bus.inst_data_ok = s_out && (s_cnt == 0);
            bus.inst_rdata = $urandom;
            bus.inst_addr_ok = !s_out && bus.inst_req && ($urandom_range(0, 1) == 1);
            #1;

            idle      = !m_inflight && !m_parked;
            mis       = (m_pc[1:0] != 2'b00);
            fresh     = m_inflight && !m_drop && bus.inst_data_ok;
            any_stall = (stall0 || stall1 || stall2 || stall3) && !irq;
            e_valid   = m_parked || fresh || (idle && mis);
            e_req     = idle && !mis;
            e_fs      = !e_valid && !irq;
            e_ins     = m_parked ? m_word : (fresh ? bus.inst_rdata : 32'h0);
            e_exc     = (idle && mis) ? 8'h01 : 8'h00;
            take      = e_valid && !any_stall && !irq;
            accepted  = e_req && bus.inst_addr_ok;

            tests_run++;
            if (bus.inst_req !== e_req || bus.inst_addr !== m_pc || fetch_stall !== e_fs ||
                Instruction !== e_ins || fetch_exc !== e_exc || PC_plus4 !== m_pc + 32'd4 ||
                is_delayslot !== id_is_branch) begin
                tests_failed++;
                $display("FAIL random cyc %0d: req=%0b/%0b addr=%h/%h stall=%0b/%0b instr=%h/%h exc=%h/%h pc4=%h/%h ds=%0b/%0b",
                         cyc, bus.inst_req, e_req, bus.inst_addr, m_pc, fetch_stall, e_fs, Instruction, e_ins,
                         fetch_exc, e_exc, PC_plus4, m_pc + 32'd4, is_delayslot, id_is_branch);
            end

            if (irq) begin
                m_pc       = exc_vector;
                m_parked   = 0;
                m_inflight = accepted || (m_inflight && !bus.inst_data_ok);
                m_drop     = m_inflight;
            end else if (take) begin
                m_pc       = branch_taken ? branch_target : m_pc + 32'd4;
                m_parked   = 0;
                m_inflight = 0;
            end else if (m_inflight && bus.inst_data_ok) begin
                if (!m_drop) begin
                    m_parked = 1;
                    m_word   = bus.inst_rdata;
                end
                m_inflight = 0;
                m_drop     = 0;
            end else if (accepted) begin
                m_inflight = 1;
            end

            if (bus.inst_data_ok) s_out = 0;
            else if (s_out) s_cnt--;
            if (bus.inst_addr_ok) begin
                s_out = 1;
                s_cnt = $urandom_range(0, 2);
            end

            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_basic_fetch();
        test_stall_hold();
        test_branch();
        test_irq_flush();
        test_misaligned();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC00000, PC loaded at reset.
REQ-002 clk  in  1  core clock; all state updates on rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 stall0..stall3  in  1 each  downstream stall requests; pipe_stall = OR of the four, forced 0 when irq=1.
REQ-005 irq  in  1  interrupt/exception flush; highest priority.
REQ-006 exc_vector  in  32  PC to fetch from after irq.
REQ-007 branch_taken  in  1  ID-stage branch resolved taken this cycle.
REQ-008 branch_target  in  32  target for branch_taken.
REQ-009 id_is_branch  in  1  instruction in ID is a branch/jump.
REQ-010 inst_req / inst_addr  out  1 / 32  SRAM-like fetch request and word address.
REQ-011 inst_addr_ok / inst_data_ok / inst_rdata  in  1 / 1 / 32  request accept, data return, read data.
REQ-012 PC_plus4 / Instruction  out  32 / 32  to IF/ID register.
REQ-013 is_delayslot  out  1  to IF/ID register.
REQ-014 fetch_exc  out  8  to IF/ID register; bit0 = AdEL (fetch misaligned), bits 7:1 = 0.
REQ-015 fetch_stall  out  1  IF has no valid instruction this cycle; OR'd into pipeline stall.

Function
REQ-016 FSM states: S_REQ, S_WAIT, S_HOLD, S_FLUSH; at most one outstanding request.
REQ-017 valid = (S_WAIT & inst_data_ok) | S_HOLD | (S_REQ & pc[1:0]!=0); fetch_stall = ~valid & ~irq.
REQ-018 advance = valid & ~pipe_stall & ~irq; on advance pc <= branch_taken ? branch_target : pc+4.
REQ-019 S_REQ, pc[1:0]==0: inst_req=1, inst_addr=pc; addr_ok -> S_WAIT; else stay.
REQ-020 S_REQ, pc[1:0]!=0: inst_req=0; Instruction=0, fetch_exc=8'h01; advance -> stay S_REQ with new pc.
REQ-021 S_WAIT: data_ok & advance -> S_REQ; data_ok & pipe_stall -> latch inst_rdata into buffer, S_HOLD.
REQ-022 S_HOLD: outputs buffer; advance -> S_REQ.
REQ-023 irq in S_REQ without addr_ok, S_HOLD, or S_WAIT with data_ok: pc <= exc_vector, -> S_REQ, returned data discarded.
REQ-024 irq in S_WAIT without data_ok, or in S_REQ with addr_ok: pc <= exc_vector, -> S_FLUSH.
REQ-025 S_FLUSH: inst_req=0, valid=0; data_ok -> S_REQ (data discarded); further irq reloads pc <= exc_vector, stays S_FLUSH.
REQ-026 irq wins over branch_taken and stalls in the same cycle.
REQ-027 Instruction = inst_rdata in S_WAIT, buffer in S_HOLD, 0 when not valid; PC_plus4 = pc+4 of current pc at all times.
REQ-028 is_delayslot = id_is_branch (combinational): the instruction delivered while a branch sits in ID is its delay slot.
REQ-029 inst_addr_ok and inst_data_ok in the same cycle is illegal; data_ok arrives at least one cycle after addr_ok.
REQ-030 pc+4 wraps modulo 2^32 (32'hFFFFFFFC -> 0).

Reset
REQ-031 rst_n=0 at an edge: pc <= RESET_PC, state <= S_REQ, buffer <= 0; overrides all other inputs, including mid-transaction.
REQ-032 During reset: inst_req=0, fetch_stall=1, Instruction=0, fetch_exc=0.

Structure
REQ-033 State encodings, RESET_PC default and fetch_exc bit positions reside in the shared CPU definitions package.
REQ-034 Single module, no sub-modules; the 32-bit hold buffer is inline.

Verification
REQ-035 Reset, addr_ok cycle 1, data_ok=32'h24020001 cycle 3, no stall -> inst_addr=BFC00000, Instruction valid cycle 3, PC_plus4=BFC00004, next inst_addr=BFC00004.
REQ-036 data_ok while stall2=1 for 3 cycles -> S_HOLD, Instruction held at same value, inst_req=0, advance on first unstalled cycle.
REQ-037 id_is_branch=1, branch_taken=1, target=BFC00100 on delivery -> is_delayslot=1, next inst_addr=BFC00100.
REQ-038 irq in S_WAIT, exc_vector=BFC00380 -> S_FLUSH, late data_ok discarded, next inst_addr=BFC00380.
REQ-039 branch_target=BFC00102 -> no inst_req, fetch_exc=8'h01, Instruction=0, valid same cycle.
REQ-040 rst_n=0 while S_WAIT -> next cycle pc=RESET_PC, state S_REQ, inst_req=0 until rst_n=1.
